// File: rtl/mem_access_stage_if.sv
// Purpose: bundles the EX->MEM inputs, the data-memory req/gnt/rvalid bus and the MEM/WB results.
// Latency: none (wires only).
// Backpressure: stall_M, driven by the stage, freezes the upstream producer of the *_E signals.
interface mem_access_stage_if #(
    parameter int N = 64
);
    // Execute-stage results
    logic         valid_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic [N-1:0] PCBranch_E;
    logic         zero_E;
    logic         Branch_E;
    logic         MemRead_E;
    logic         MemWrite_E;
    logic         RegWrite_E;
    logic         MemtoReg_E;
    logic [4:0]   rd_E;

    // Data-memory bus
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_gnt;
    logic         dm_rvalid;
    logic [N-1:0] dm_rdata;

    // Pipeline control and branch resolution
    logic         stall_M;
    logic         PCSrc_M;
    logic [N-1:0] PCBranch_M;

    // Writeback results
    logic         valid_W;
    logic         RegWrite_W;
    logic         MemtoReg_W;
    logic [4:0]   rd_W;
    logic [N-1:0] aluResult_W;
    logic [N-1:0] readData_W;
    logic         mem_err;

    // Environment side: execute stage, data memory and writeback consumer
    modport master (
        output valid_E, aluResult_E, writeData_E, PCBranch_E, zero_E,
               Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, rd_E,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  stall_M, PCSrc_M, PCBranch_M,
        input  valid_W, RegWrite_W, MemtoReg_W, rd_W, aluResult_W, readData_W, mem_err
    );

    // Memory-access stage side
    modport slave (
        input  valid_E, aluResult_E, writeData_E, PCBranch_E, zero_E,
               Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, rd_E,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output stall_M, PCSrc_M, PCBranch_M,
        output valid_W, RegWrite_W, MemtoReg_W, rd_W, aluResult_W, readData_W, mem_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Purpose: EX/MEM latch, branch resolution, data-memory req/gnt/rvalid master, MEM/WB latch.
// Latency: EX->W 2 edges for ALU ops and zero-wait stores, 3+ edges for loads.
// Backpressure: stall_M holds upstream while a memory access is outstanding.
// Optional build macro MEM_TIMEOUT_EN adds a load-response timeout reported on mem_err.
module mem_access_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_stage_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;

    // A non-positive TIMEOUT has no meaningful counter compare; keep it visible at elaboration.
    if (TIMEOUT < 1) begin : g_timeout_must_be_positive
    end

    // EX/MEM registers
    logic         valid_M_q;
    logic [N-1:0] alu_M_q;
    logic [N-1:0] wdata_M_q;
    logic [N-1:0] pcbr_M_q;
    logic         zero_M_q;
    logic         branch_M_q;
    logic         memread_M_q;
    logic         memwrite_M_q;
    logic         regwrite_M_q;
    logic         memtoreg_M_q;
    logic [4:0]   rd_M_q;

    // Access FSM
    logic [1:0]   state_q;
    logic [1:0]   state_d;

    // MEM/WB registers
    logic         valid_W_q,    valid_W_d;
    logic         regwrite_W_q, regwrite_W_d;
    logic         memtoreg_W_q, memtoreg_W_d;
    logic [4:0]   rd_W_q,       rd_W_d;
    logic [N-1:0] alu_W_q,      alu_W_d;
    logic [N-1:0] rdata_W_q,    rdata_W_d;
    logic         mem_err_q,    mem_err_d;

    logic memop_M;
    logic load_M;
    logic gnt_ok;
    logic rv_ok;
    logic timeout_hit;
    logic complete;
    logic stall;
    logic advance;

    // Both MemRead and MemWrite set behaves as a store, so "load" excludes MemWrite.
    assign memop_M = memread_M_q | memwrite_M_q;
    assign load_M  = memread_M_q & ~memwrite_M_q;
    // Responses only count in the state that expects them; strays elsewhere are dropped.
    assign gnt_ok  = (state_q == S_REQ)    & bus.dm_gnt;
    assign rv_ok   = (state_q == S_WAIT_R) & bus.dm_rvalid;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_q;

    // Count cycles spent in WAIT_R; the counter is zero on the first WAIT_R cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_WAIT_R) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // A real response on the final cycle wins over the timeout.
    assign timeout_hit = (state_q == S_WAIT_R) & ~bus.dm_rvalid & (wait_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = (gnt_ok & memwrite_M_q) | rv_ok | timeout_hit;
    assign stall    = valid_M_q & memop_M & ~complete;
    assign advance  = ~stall;

    // Bus and pipeline-control outputs, all decoded from registered state.
    assign bus.dm_req     = (state_q == S_REQ);
    assign bus.dm_we      = (state_q == S_REQ) & memwrite_M_q;
    assign bus.dm_addr    = alu_M_q;
    assign bus.dm_wdata   = wdata_M_q;
    assign bus.stall_M    = stall;
    assign bus.PCSrc_M    = valid_M_q & branch_M_q & zero_M_q;
    assign bus.PCBranch_M = pcbr_M_q;

    assign bus.valid_W     = valid_W_q;
    assign bus.RegWrite_W  = regwrite_W_q;
    assign bus.MemtoReg_W  = memtoreg_W_q;
    assign bus.rd_W        = rd_W_q;
    assign bus.aluResult_W = alu_W_q;
    assign bus.readData_W  = rdata_W_q;
    assign bus.mem_err     = mem_err_q;

    // EX/MEM latch: capture the execute results whenever the stage is not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_M_q    <= 1'b0;
            alu_M_q      <= '0;
            wdata_M_q    <= '0;
            pcbr_M_q     <= '0;
            zero_M_q     <= 1'b0;
            branch_M_q   <= 1'b0;
            memread_M_q  <= 1'b0;
            memwrite_M_q <= 1'b0;
            regwrite_M_q <= 1'b0;
            memtoreg_M_q <= 1'b0;
            rd_M_q       <= '0;
        end else if (advance) begin
            valid_M_q    <= bus.valid_E;
            alu_M_q      <= bus.aluResult_E;
            wdata_M_q    <= bus.writeData_E;
            pcbr_M_q     <= bus.PCBranch_E;
            zero_M_q     <= bus.zero_E;
            branch_M_q   <= bus.Branch_E;
            memread_M_q  <= bus.MemRead_E;
            memwrite_M_q <= bus.MemWrite_E;
            regwrite_M_q <= bus.RegWrite_E;
            memtoreg_M_q <= bus.MemtoReg_E;
            rd_M_q       <= bus.rd_E;
        end
    end

    // Next access state: a newly latched memory op starts in REQ; a granted load waits for data.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = (bus.valid_E & (bus.MemRead_E | bus.MemWrite_E)) ? S_REQ : S_IDLE;
        end else if (gnt_ok) begin
            state_d = S_WAIT_R;
        end
    end

    // Access state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB next values: move on advance, insert a bubble while stalled.
    always_comb begin
        valid_W_d    = 1'b0;
        regwrite_W_d = regwrite_W_q;
        memtoreg_W_d = memtoreg_W_q;
        rd_W_d       = rd_W_q;
        alu_W_d      = alu_W_q;
        rdata_W_d    = rdata_W_q;
        mem_err_d    = 1'b0;
        if (advance) begin
            valid_W_d    = valid_M_q;
            regwrite_W_d = regwrite_M_q;
            memtoreg_W_d = memtoreg_M_q;
            rd_W_d       = rd_M_q;
            alu_W_d      = alu_M_q;
            if (valid_M_q & load_M) begin
                // A timed-out load delivers zero data.
                rdata_W_d = rv_ok ? bus.dm_rdata : '0;
                mem_err_d = timeout_hit;
            end
        end
    end

    // MEM/WB latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_W_q    <= 1'b0;
            regwrite_W_q <= 1'b0;
            memtoreg_W_q <= 1'b0;
            rd_W_q       <= '0;
            alu_W_q      <= '0;
            rdata_W_q    <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            valid_W_q    <= valid_W_d;
            regwrite_W_q <= regwrite_W_d;
            memtoreg_W_q <= memtoreg_W_d;
            rd_W_q       <= rd_W_d;
            alu_W_q      <= alu_W_d;
            rdata_W_q    <= rdata_W_d;
            mem_err_q    <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: directed self-checking bench for mem_access_stage.
// Latency: checks 2-edge ALU/store and 3+-edge load paths through to writeback.
// Backpressure: exercises stall_M during delayed grant / delayed load data.
module tb_mem_access_stage;

    localparam int N = 64;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   stall_cnt;

    mem_access_stage_if #(.N(N)) bus ();

    mem_access_stage #(.N(N), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.valid_E     = 1'b0;
        bus.aluResult_E = '0;
        bus.writeData_E = '0;
        bus.PCBranch_E  = '0;
        bus.zero_E      = 1'b0;
        bus.Branch_E    = 1'b0;
        bus.MemRead_E   = 1'b0;
        bus.MemWrite_E  = 1'b0;
        bus.RegWrite_E  = 1'b0;
        bus.MemtoReg_E  = 1'b0;
        bus.rd_E        = '0;
    endtask

    task automatic drive_load(input logic [N-1:0] addr, input logic [4:0] rd);
        clear_ex();
        bus.valid_E     = 1'b1;
        bus.aluResult_E = addr;
        bus.MemRead_E   = 1'b1;
        bus.RegWrite_E  = 1'b1;
        bus.MemtoReg_E  = 1'b1;
        bus.rd_E        = rd;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_ex();
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = '0;
        reset = 1'b0;
        #12;
        // Reset state
        chk("rst_dm_req",  {63'd0, bus.dm_req},  64'd0);
        chk("rst_stall",   {63'd0, bus.stall_M}, 64'd0);
        chk("rst_valid_W", {63'd0, bus.valid_W}, 64'd0);
        chk("rst_PCSrc",   {63'd0, bus.PCSrc_M}, 64'd0);
        chk("rst_mem_err", {63'd0, bus.mem_err}, 64'd0);
        chk("rst_rdata_W", bus.readData_W,       64'd0);
        reset = 1'b1;
        step();

        // ADD rd=3, alu=0x10
        clear_ex();
        bus.valid_E = 1'b1; bus.RegWrite_E = 1'b1; bus.rd_E = 5'd3; bus.aluResult_E = 64'h10;
        step();
        clear_ex();
        chk("add_stall", {63'd0, bus.stall_M}, 64'd0);
        chk("add_req",   {63'd0, bus.dm_req},  64'd0);
        chk("add_vW_early", {63'd0, bus.valid_W}, 64'd0);
        step();
        chk("add_valid_W", {63'd0, bus.valid_W},    64'd1);
        chk("add_alu_W",   bus.aluResult_W,         64'h10);
        chk("add_rd_W",    {59'd0, bus.rd_W},       64'd3);
        chk("add_regw_W",  {63'd0, bus.RegWrite_W}, 64'd1);

        // STUR addr=0x20 data=0xAB, grant in the same cycle as the request
        clear_ex();
        bus.valid_E = 1'b1; bus.MemWrite_E = 1'b1; bus.aluResult_E = 64'h20; bus.writeData_E = 64'hAB;
        bus.dm_gnt = 1'b1;
        step();
        clear_ex();
        chk("st_req",   {63'd0, bus.dm_req},  64'd1);
        chk("st_we",    {63'd0, bus.dm_we},   64'd1);
        chk("st_addr",  bus.dm_addr,          64'h20);
        chk("st_wdata", bus.dm_wdata,         64'hAB);
        chk("st_stall", {63'd0, bus.stall_M}, 64'd0);
        step();
        bus.dm_gnt = 1'b0;
        chk("st_req_one_cycle", {63'd0, bus.dm_req},     64'd0);
        chk("st_valid_W",       {63'd0, bus.valid_W},    64'd1);
        chk("st_memtoreg_W",    {63'd0, bus.MemtoReg_W}, 64'd0);
        chk("st_alu_W",         bus.aluResult_W,         64'h20);

        // LDUR addr=0x40 rd=7; gnt on third REQ cycle, rvalid three cycles later.
        // An ADD rd=9 waits behind it on the EX outputs the whole time.
        drive_load(64'h40, 5'd7);
        step();
        clear_ex();
        bus.valid_E = 1'b1; bus.RegWrite_E = 1'b1; bus.rd_E = 5'd9; bus.aluResult_E = 64'h99;
        stall_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.dm_gnt    = (k == 2);
            bus.dm_rvalid = (k == 1) || (k == 5);
            bus.dm_rdata  = (k == 1) ? 64'hBAD : 64'hDEAD_BEEF;
            #1;
            if (bus.stall_M) stall_cnt++;
            if (k == 1) chk("ld_req_c1",   {63'd0, bus.dm_req},  64'd1);
            if (k == 3) chk("ld_req_c3",   {63'd0, bus.dm_req},  64'd0);
            if (k == 3) chk("ld_vW_stall", {63'd0, bus.valid_W}, 64'd0);
            if (k == 4) chk("ld_addr_held", bus.dm_addr,         64'h40);
            step();
        end
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
        chk("ld_stall_cycles", 64'(stall_cnt),                 64'd5);
        chk("ld_valid_W",      {63'd0, bus.valid_W},           64'd1);
        chk("ld_rdata_W",      bus.readData_W,                 64'hDEAD_BEEF);
        chk("ld_memtoreg_W",   {63'd0, bus.MemtoReg_W},        64'd1);
        chk("ld_rd_W",         {59'd0, bus.rd_W},              64'd7);
        clear_ex();
        step();
        chk("held_add_rd_W",   {59'd0, bus.rd_W},              64'd9);
        chk("held_add_alu_W",  bus.aluResult_W,                64'h99);
        chk("held_add_rdata",  bus.readData_W,                 64'hDEAD_BEEF);

        // CBZ taken then not taken
        clear_ex();
        bus.valid_E = 1'b1; bus.Branch_E = 1'b1; bus.zero_E = 1'b1; bus.PCBranch_E = 64'h200;
        step();
        chk("cbz_pcsrc",  {63'd0, bus.PCSrc_M}, 64'd1);
        chk("cbz_target", bus.PCBranch_M,       64'h200);
        bus.zero_E = 1'b0; bus.PCBranch_E = 64'h300;
        step();
        clear_ex();
        chk("cbz_nt_pcsrc",  {63'd0, bus.PCSrc_M}, 64'd0);
        chk("cbz_nt_target", bus.PCBranch_M,       64'h300);

        // Load with no data response
        drive_load(64'h60, 5'd4);
        step();
        clear_ex();
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int w = 0; w < 16; w++) begin
            #1;
            if (w == 14) chk("to_stall_w14", {63'd0, bus.stall_M}, 64'd1);
            if (w == 15) chk("to_stall_w15", {63'd0, bus.stall_M}, 64'd0);
            step();
        end
        chk("to_mem_err",  {63'd0, bus.mem_err}, 64'd1);
        chk("to_valid_W",  {63'd0, bus.valid_W}, 64'd1);
        chk("to_rdata_W",  bus.readData_W,       64'd0);
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 64'h1234;
        step();
        bus.dm_rvalid = 1'b0;
        chk("to_err_pulse", {63'd0, bus.mem_err}, 64'd0);
        chk("to_late_rv",   {63'd0, bus.valid_W}, 64'd0);
        chk("to_late_data", bus.readData_W,       64'd0);
`else
        for (int w = 0; w < 20; w++) begin
            #1;
            if (w == 19) chk("wait_stall", {63'd0, bus.stall_M}, 64'd1);
            if (w == 19) chk("wait_err",   {63'd0, bus.mem_err}, 64'd0);
            step();
        end
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 64'h1234;
        step();
        bus.dm_rvalid = 1'b0;
        chk("wait_valid_W", {63'd0, bus.valid_W}, 64'd1);
        chk("wait_rdata_W", bus.readData_W,       64'h1234);
        chk("wait_err_W",   {63'd0, bus.mem_err}, 64'd0);
`endif

        // Reset in the middle of a load (WAIT_R), then stray rvalid in IDLE
        drive_load(64'h80, 5'd5);
        step();
        clear_ex();
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        step();
        chk("mid_stall", {63'd0, bus.stall_M}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_dm_req",  {63'd0, bus.dm_req},  64'd0);
        chk("arst_stall",   {63'd0, bus.stall_M}, 64'd0);
        chk("arst_valid_W", {63'd0, bus.valid_W}, 64'd0);
        step();
        reset = 1'b1;
        bus.dm_rvalid = 1'b1; bus.dm_rdata = 64'h5555;
        step();
        step();
        bus.dm_rvalid = 1'b0;
        chk("stray_valid_W", {63'd0, bus.valid_W}, 64'd0);
        chk("stray_rdata_W", bus.readData_W,       64'd0);
        chk("stray_stall",   {63'd0, bus.stall_M}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
